uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter among N requesters: the fetch unit plus each bitty core. It replaces the static uart_sel multiplexing with round-robin arbitration. A granted requester owns the transmitter for one byte, from tx_en through tx_done. The block sits between the requesters and uart_module's data_tx/tx_en/tx_done ports, and returns a one-cycle acknowledge to the winner.

## Interface
- NUM_REQ, 3: number of requesters (2..8); index 0 = fetch unit, 1.. = bitty cores.
- DATA_W, 8: byte width on the UART TX path.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low; clock clk.
- req  in  NUM_REQ  per-requester level request; held until ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W].
- req_lock  in  NUM_REQ  keep grant for a further byte (used only with UART_ARB_LOCK_EN).
- ack  out  NUM_REQ  one-cycle pulse: byte from requester i fully transmitted.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high in any state other than IDLE.
- uart_tx_en  out  1  one-cycle start pulse to uart_module.tx_en.
- uart_tx_data  out  DATA_W  latched byte to uart_module.data_tx.
- uart_tx_done  in  1  one-cycle completion pulse from uart_module.

## Operation
- States: IDLE, START, WAIT.
- IDLE: if any req bit is high, select the winner round-robin. The search starts at last_ptr+1 mod NUM_REQ. On that edge: register grant, latch req_data of the winner into uart_tx_data, go to START.
- START: uart_tx_en=1 for exactly this cycle, then go to WAIT unconditionally.
- WAIT: hold grant and uart_tx_data. On uart_tx_done=1: pulse ack[winner] in the next cycle, set last_ptr to the winner, and go to IDLE, clearing grant.
- uart_tx_done is ignored in IDLE and START.
- If req[winner] drops during START or WAIT, it is ignored. The byte completes and ack is still issued.
- req_data changes after the grant edge are ignored, because the byte is latched.
- A new req from a non-owner during WAIT waits. It is arbitrated in the next IDLE.
- Reset values: state=IDLE, grant=0, ack=0, busy=0, uart_tx_en=0, uart_tx_data=0.
- last_ptr resets to NUM_REQ-1, so requester 0 (fetch) wins first after reset.
- Reset mid-transfer aborts the byte with no ack. The requester must re-request.

## Timing
- req high sampled at edge k in IDLE gives, after edge k: grant valid, uart_tx_en=1 for one cycle, busy=1.
- After edge k+1: state WAIT, uart_tx_en=0.
- uart_tx_done sampled at edge m gives, after edge m: ack pulse, grant=0, state IDLE.
- The earliest next grant is after edge m+1. The back-to-back gap is one IDLE cycle.
- Minimum transfer occupancy is 3 cycles plus UART frame time.
- Simultaneous requests in the same cycle: exactly one grant, chosen by round-robin order, never two.
- Starvation bound: a held request is served within NUM_REQ transfers.

## Configuration
- UART_ARB_LOCK_EN defined:
  - In WAIT on uart_tx_done, if req_lock[winner] and req[winner] are both high: pulse ack, keep grant, latch the new req_data, go directly to START.
  - last_ptr is not updated while the lock continues.
  - This supports multi-byte responses from bitty without interleaving.
- UART_ARB_LOCK_EN undefined: req_lock is ignored and every byte is re-arbitrated.

## Structure
- Shared package uart_arb_pkg:
  - state enum (IDLE, START, WAIT);
  - NUM_REQ_DEFAULT;
  - DATA_W_DEFAULT.
- Sub-module rr_picker:
  - combinational round-robin search;
  - inputs req and last_ptr; outputs one-hot pick and pick_idx.
  - Instantiated once.

## Test plan
- Single request: req=3'b001 with byte 8'hA5 → one uart_tx_en pulse, uart_tx_data=8'hA5, grant=3'b001. Then tx_done → ack=3'b001 for one cycle.
- Simultaneous requests: req=3'b111 held after reset → grant order 0,1,2,0 across four tx_done pulses.
- Late arrival: req1 rises during a WAIT on requester 0 → no grant change until done. Requester 1 is granted one cycle after IDLE is entered.
- Protocol robustness: spurious uart_tx_done in IDLE → no ack, no state change. req_data changed in WAIT → uart_tx_data unchanged.
- Reset mid-transfer: reset low in WAIT → all outputs 0 the next cycle, no ack. Requester 0 wins first afterwards.
- Lock mode (UART_ARB_LOCK_EN): requester 2 holds req_lock with req=3'b101 pending from others → requester 2 sends 3 bytes consecutively, then requester 0 is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 3;
  localparam int DATA_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit strictly after last_ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int               cand;
      logic [IDX_W-1:0] idx;
      cand = (int'(last_ptr) + off) % NUM_REQ;
      idx  = IDX_W'(cand);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter, one byte per grant.
// Define UART_ARB_LOCK_EN to let the owner keep the grant across bytes via req_lock.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate any pending req
// S_START | owner granted, uart_tx_en high this cycle
// S_WAIT  | byte in flight, waiting for uart_tx_done
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      uart_tx_en,
  output logic [DATA_W-1:0]         uart_tx_data,
  input  logic                      uart_tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last_ptr, last_ptr_nxt;
  logic [IDX_W-1:0] win_idx, win_idx_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick, grant_nxt, ack_nxt;
  logic [DATA_W-1:0]  tx_data_nxt;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  logic               lock_hold;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

`ifdef UART_ARB_LOCK_EN
  assign lock_hold = req_lock[win_idx] & req[win_idx];
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
  assign lock_hold       = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ack_nxt      = '0;
    tx_data_nxt  = uart_tx_data;
    last_ptr_nxt = last_ptr;
    win_idx_nxt  = win_idx;
    case (state)
      S_IDLE: begin
        if (|req) begin
          grant_nxt   = pick;
          win_idx_nxt = pick_idx;
          tx_data_nxt = req_bytes[pick_idx];
          state_nxt   = S_START;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (uart_tx_done) begin
          ack_nxt = grant;
          if (lock_hold) begin
            // Locked owner streams its next byte; pointer stays put so the
            // rotation resumes where it would have without the lock.
            tx_data_nxt = req_bytes[win_idx];
            state_nxt   = S_START;
          end else begin
            grant_nxt    = '0;
            last_ptr_nxt = win_idx;
            state_nxt    = S_IDLE;
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      grant        <= '0;
      ack          <= '0;
      uart_tx_data <= '0;
      last_ptr     <= IDX_W'(NUM_REQ - 1);
      win_idx      <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      ack          <= ack_nxt;
      uart_tx_data <= tx_data_nxt;
      last_ptr     <= last_ptr_nxt;
      win_idx      <= win_idx_nxt;
    end
  end

  assign busy       = (state != S_IDLE);
  assign uart_tx_en = (state == S_START);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (3 requesters, 8-bit bytes).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_lock;
  logic [2:0]  ack;
  logic [2:0]  grant;
  logic        busy;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .ack          (ack),
    .grant        (grant),
    .busy         (busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_done (uart_tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive/sample at the negedge, one active edge per call.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [2:0] exp_order [4];
  logic [7:0] exp_bytes [4];

  initial begin
    reset        = 1'b0;
    req          = '0;
    req_data     = '0;
    req_lock     = '0;
    uart_tx_done = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_en", 32'(uart_tx_en), 32'h0);
    check("rst_tx_data", 32'(uart_tx_data), 32'h0);
    reset = 1'b1;

    // single request
    req = 3'b001;
    set_byte(0, 8'hA5);
    step();
    check("single_grant", 32'(grant), 32'h1);
    check("single_tx_en", 32'(uart_tx_en), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_data", 32'(uart_tx_data), 32'hA5);
    step();
    check("single_tx_en_low", 32'(uart_tx_en), 32'h0);
    check("single_busy_wait", 32'(busy), 32'h1);
    step();
    check("single_no_early_ack", 32'(ack), 32'h0);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = '0;
    check("single_ack", 32'(ack), 32'h1);
    check("single_grant_clr", 32'(grant), 32'h0);
    check("single_idle", 32'(busy), 32'h0);
    step();
    check("single_ack_one_cycle", 32'(ack), 32'h0);
    check("single_no_regrant", 32'(uart_tx_en), 32'h0);

    // simultaneous requests after reset: order 0,1,2,0
    pulse_reset();
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    exp_bytes[0] = 8'h11;  exp_bytes[1] = 8'h22;  exp_bytes[2] = 8'h33;  exp_bytes[3] = 8'h11;
    set_byte(0, 8'h11);
    set_byte(1, 8'h22);
    set_byte(2, 8'h33);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_order[i]));
      check($sformatf("rr_data%0d", i), 32'(uart_tx_data), 32'(exp_bytes[i]));
      check($sformatf("rr_tx_en%0d", i), 32'(uart_tx_en), 32'h1);
      step();
      uart_tx_done = 1'b1;
      step();
      uart_tx_done = 1'b0;
      check($sformatf("rr_ack%0d", i), 32'(ack), 32'(exp_order[i]));
      check($sformatf("rr_gap%0d", i), 32'(grant), 32'h0);
    end
    req = '0;
    step();

    // late arrival and req_data change in WAIT (last winner was 0)
    req = 3'b001;
    set_byte(0, 8'h44);
    step();
    check("late_grant0", 32'(grant), 32'h1);
    step();
    req = 3'b011;
    set_byte(1, 8'h55);
    set_byte(0, 8'h99);
    step();
    step();
    check("late_hold_grant", 32'(grant), 32'h1);
    check("late_data_latched", 32'(uart_tx_data), 32'h44);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = 3'b010;
    check("late_ack0", 32'(ack), 32'h1);
    check("late_idle_grant", 32'(grant), 32'h0);
    step();
    check("late_grant1", 32'(grant), 32'h2);
    check("late_data1", 32'(uart_tx_data), 32'h55);
    step();
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = '0;
    check("late_ack1", 32'(ack), 32'h2);

    // spurious done in IDLE and in START (last winner 1)
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    check("spur_idle_ack", 32'(ack), 32'h0);
    check("spur_idle_busy", 32'(busy), 32'h0);
    req = 3'b001;
    set_byte(0, 8'h66);
    step();
    check("spur_grant", 32'(grant), 32'h1);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    check("spur_start_ack", 32'(ack), 32'h0);
    check("spur_start_busy", 32'(busy), 32'h1);
    step();
    check("spur_still_wait", 32'(grant), 32'h1);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = '0;
    check("spur_ack", 32'(ack), 32'h1);

    // reset mid-transfer (last winner 0, so requester 1 wins next)
    req = 3'b010;
    set_byte(1, 8'h77);
    step();
    check("mid_grant1", 32'(grant), 32'h2);
    step();
    reset = 1'b0;
    uart_tx_done = 1'b1;
    step();
    reset = 1'b1;
    uart_tx_done = 1'b0;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_tx_en", 32'(uart_tx_en), 32'h0);
    check("mid_rst_data", 32'(uart_tx_data), 32'h0);
    req = 3'b011;
    set_byte(0, 8'h88);
    step();
    check("mid_fetch_first", 32'(grant), 32'h1);
    check("mid_fetch_data", 32'(uart_tx_data), 32'h88);
    step();
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = '0;
    check("mid_ack", 32'(ack), 32'h1);
    step();

`ifdef UART_ARB_LOCK_EN
    // requester 2 streams three bytes under lock, then requester 0 is served
    pulse_reset();
    req      = 3'b100;
    req_lock = 3'b100;
    set_byte(0, 8'hB0);
    set_byte(2, 8'hA1);
    step();
    check("lock_grant", 32'(grant), 32'h4);
    check("lock_byte0", 32'(uart_tx_data), 32'hA1);
    step();
    req = 3'b101;
    set_byte(2, 8'hA2);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    check("lock_ack0", 32'(ack), 32'h4);
    check("lock_keep0", 32'(grant), 32'h4);
    check("lock_byte1", 32'(uart_tx_data), 32'hA2);
    check("lock_tx_en1", 32'(uart_tx_en), 32'h1);
    step();
    set_byte(2, 8'hA3);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    check("lock_ack1", 32'(ack), 32'h4);
    check("lock_byte2", 32'(uart_tx_data), 32'hA3);
    step();
    req_lock = '0;
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = 3'b001;
    check("lock_ack2", 32'(ack), 32'h4);
    check("lock_release", 32'(grant), 32'h0);
    step();
    check("lock_next_fetch", 32'(grant), 32'h1);
    check("lock_next_data", 32'(uart_tx_data), 32'hB0);
    step();
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    req = '0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
